// File: rtl/sum_link_rx.sv
// sum_link_rx: receive side of the inter-core softmax-denominator exchange.
// Drains the peer core's external sum FIFO into a small local circular buffer,
// presents the head word on sum_in and gates local division strobes on data
// availability.
// Optional feature: define SUM_LINK_STALL_CNT_EN to add the stall_cnt output.
module sum_link_rx #(
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int depth   = 4,
    parameter int cnt_w   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 peer_wr,
    output logic                 fifo_ext_rd,
    input  logic [bw_psum+3:0]   peer_sum,
    input  logic                 div_req,
    output logic                 div,
    output logic [bw_psum+3:0]   sum_in,
    output logic                 div_stall,
`ifdef SUM_LINK_STALL_CNT_EN
    output logic [15:0]          stall_cnt,
`endif
    output logic                 ovf_err
);

    localparam int SW = bw_psum + 4;
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [cnt_w-1:0] CRED_MAX = cnt_w'(16);

    typedef enum logic [1:0] {IDLE, RD, CAP} state_t;

    state_t            state, state_next;
    logic [cnt_w-1:0]  credits;
    logic [SW-1:0]     mem [depth];
    logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_nxt;
    logic [PW:0]       count, count_next, avail;
    logic              wr_en;
    logic              pop;
    logic              slot_free;
    logic [SW-1:0]     head_word;

    assign wr_en      = (state == CAP);
    assign count_next = count + (PW+1)'(wr_en) - (PW+1)'(pop);
    // A slot is free only if it stays free after this cycle's write/pop; RD then reserves it for CAP
    assign slot_free  = (count_next < (PW+1)'(depth));
    // Entries not yet claimed by an issued div (div pending or pop in progress)
    assign avail      = count - (PW+1)'(div) - (PW+1)'(pop);
    assign rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
    // New head after this edge: the CAP word itself when it lands on an otherwise empty buffer
    assign head_word  = (wr_en && (wr_ptr == rd_ptr_nxt)) ? peer_sum : mem[rd_ptr_nxt];
    assign div_stall  = div_req & (count == '0);

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Read FSM next state and read strobe; RD always separated by CAP
    always_comb begin
        state_next  = state;
        fifo_ext_rd = 1'b0;
        case (state)
            IDLE: if (credits != '0 && slot_free) state_next = RD;
            RD: begin
                fifo_ext_rd = 1'b1;
                state_next  = CAP;
            end
            CAP: state_next = (credits != '0 && slot_free) ? RD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Peer-entry credits and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            credits <= '0;
            ovf_err <= 1'b0;
        end else begin
            case ({peer_wr, fifo_ext_rd})
                2'b10: begin
                    if (credits == CRED_MAX) ovf_err <= 1'b1;
                    else                     credits <= credits + cnt_w'(1);
                end
                2'b01:   credits <= credits - cnt_w'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Buffer storage written at the tail in CAP
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= peer_sum;
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_next;
        end
    end

    // Registered head word; holds its last value while the buffer is empty
    always_ff @(posedge clk) begin
        if (reset)                  sum_in <= '0;
        else if (count_next != '0)  sum_in <= head_word;
    end

    // Division strobe, and pop one cycle after it so sum_in holds through div and div_q
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= 1'b0;
            pop <= 1'b0;
        end else begin
            div <= div_req & ~div & (avail != '0);
            pop <= div;
        end
    end

`ifdef SUM_LINK_STALL_CNT_EN
    // Saturating count of stalled division-request cycles
    always_ff @(posedge clk) begin
        if (reset)                              stall_cnt <= '0;
        else if (div_stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
